// File: rtl/sigmoid_pkg.sv
// Shared fixed-point constants and sigmoid sample table for the LSTM sigmoid path.
// Used by the segment fetch stage, the interpolator and their golden models.
package sigmoid_pkg;

   localparam int DATA_W      = 8;
   localparam int FRAC_W      = 4;
   localparam int TABLE_DEPTH = 17;

   typedef logic signed [DATA_W-1:0] sample_t;

   // round(16 * sigmoid(k - 8)) for k = 0..16, in Q4.4.
   localparam sample_t SIGMOID_TABLE [TABLE_DEPTH] = '{
      8'sd0,  8'sd0,  8'sd0,  8'sd0,  8'sd0,  8'sd1,  8'sd2,  8'sd4,
      8'sd8,  8'sd12, 8'sd14, 8'sd15, 8'sd16, 8'sd16, 8'sd16, 8'sd16,
      8'sd16
   };

endpackage

// File: rtl/sigmoid_sample_rom.sv
// Constant case-ROM of the 17 sigmoid samples; addresses above 16 read as 0.
module sigmoid_sample_rom
   import sigmoid_pkg::*;
(
   input  logic [4:0] addr,
   output sample_t    data
);

   always_comb begin
      // NOTE: default first so every path assigns data and no latch is inferred.
      data = '0;
      case (addr)
         5'd0:  data = 8'sd0;
         5'd1:  data = 8'sd0;
         5'd2:  data = 8'sd0;
         5'd3:  data = 8'sd0;
         5'd4:  data = 8'sd0;
         5'd5:  data = 8'sd1;
         5'd6:  data = 8'sd2;
         5'd7:  data = 8'sd4;
         5'd8:  data = 8'sd8;
         5'd9:  data = 8'sd12;
         5'd10: data = 8'sd14;
         5'd11: data = 8'sd15;
         5'd12: data = 8'sd16;
         5'd13: data = 8'sd16;
         5'd14: data = 8'sd16;
         5'd15: data = 8'sd16;
         5'd16: data = 8'sd16;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/sigmoid_segment_fetch.sv
// Two-stage segment fetch feeding the sigmoid PWL interpolator (valid/ready, 1 sample/cycle).
// Define SIGMOID_SEGMENT_FETCH_STATS_EN to add the saturating 16-bit out_count transfer counter.
module sigmoid_segment_fetch
   import sigmoid_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int FRAC_W      = 4,
   parameter int TABLE_DEPTH = 17
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic        [DATA_W-1:0] in_x,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] base,
   output logic signed [DATA_W-1:0] next_data,
   output logic signed [DATA_W-1:0] change,
   output logic        [DATA_W-1:0] remaining,
   output logic                     out_valid,
   input  logic                     out_ready
`ifdef SIGMOID_SEGMENT_FETCH_STATS_EN
   ,
   output logic [15:0]              out_count
`endif
);

   localparam int IDX_W  = DATA_W - FRAC_W;
   localparam int ADDR_W = $clog2(TABLE_DEPTH);

   logic              advance;
   logic              s1_valid;
   logic [IDX_W-1:0]  s1_index;
   logic [FRAC_W-1:0] s1_rem;
   logic [ADDR_W-1:0] addr_lo;
   logic [ADDR_W-1:0] addr_hi;
   sample_t           rom_lo;
   sample_t           rom_hi;

   // Whole pipe moves together; it only freezes when a held output is not taken.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Flipping the sign bit turns the signed integer part into an offset-binary index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_index <= '0;
         s1_rem   <= '0;
      end else if (advance) begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
         s1_valid <= in_valid;
         s1_index <= {~in_x[DATA_W-1], in_x[DATA_W-2:FRAC_W]};
         s1_rem   <= in_x[FRAC_W-1:0];
      end
   end

   assign addr_lo = ADDR_W'(s1_index);
   assign addr_hi = addr_lo + ADDR_W'(1);

   sigmoid_sample_rom u_rom_lo (.addr(addr_lo), .data(rom_lo));
   sigmoid_sample_rom u_rom_hi (.addr(addr_hi), .data(rom_hi));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         base      <= '0;
         next_data <= '0;
         change    <= '0;
         remaining <= '0;
      end else if (advance) begin
         out_valid <= s1_valid;
         base      <= rom_lo;
         next_data <= rom_hi;
         change    <= rom_hi - rom_lo;
         remaining <= {{(DATA_W-FRAC_W){1'b0}}, s1_rem};
      end
   end

`ifdef SIGMOID_SEGMENT_FETCH_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_count <= '0;
      end else if (out_valid && out_ready && (out_count != 16'hFFFF)) begin
         out_count <= out_count + 16'd1;
      end
   end
`else
   // Default build carries no transfer counter.
`endif

endmodule

// File: tb/tb_sigmoid_segment_fetch.sv
// Self-checking bench: random valid/ready traffic against a queue-based table model, plus directed cases.
// Build with SIGMOID_SEGMENT_FETCH_STATS_EN to also exercise out_count.
module tb_sigmoid_segment_fetch;
   import sigmoid_pkg::*;

   logic              clk;
   logic              rst;
   logic        [7:0] in_x;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] base;
   logic signed [7:0] next_data;
   logic signed [7:0] change;
   logic        [7:0] remaining;
   logic              out_valid;
   logic              out_ready;
`ifdef SIGMOID_SEGMENT_FETCH_STATS_EN
   logic [15:0]       out_count;
   int                stat_exp;
`endif

   int vectors;
   int miscompares;
   int cyc;

   typedef struct {
      logic [31:0] tup;
      int          acc;
   } exp_t;

   exp_t exp_q[$];

   sigmoid_segment_fetch dut (
      .clk(clk),
      .rst(rst),
      .in_x(in_x),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .base(base),
      .next_data(next_data),
      .change(change),
      .remaining(remaining),
      .out_valid(out_valid),
      .out_ready(out_ready)
`ifdef SIGMOID_SEGMENT_FETCH_STATS_EN
      ,
      .out_count(out_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Segment = floor(x / 1.0) + 8 in Q4.4; fraction = x mod 1.0.
   function automatic logic [31:0] model(input logic [7:0] x);
      int      xi;
      int      idx;
      sample_t b;
      sample_t n;
      sample_t d;
      xi  = int'($signed(x));
      idx = (xi >>> 4) + 8;
      b   = SIGMOID_TABLE[idx];
      n   = SIGMOID_TABLE[idx+1];
      d   = n - b;
      return {b, n, d, x & 8'h0F};
   endfunction

   function automatic logic [31:0] outs();
      return {base, next_data, change, remaining};
   endfunction

   // Compare process: every negedge, DUT outputs against the head of the expected queue.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         exp_q.delete();
`ifdef SIGMOID_SEGMENT_FETCH_STATS_EN
         stat_exp = 0;
`endif
      end else begin
         check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
`ifdef SIGMOID_SEGMENT_FETCH_STATS_EN
         check("out_count", {16'b0, out_count}, stat_exp);
`endif
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 32'd1, 32'd0);
            end else begin
               check("early_out", {31'b0, (exp_q[0].acc + 2 <= cyc)}, 32'd1);
               check("out_tuple", outs(), exp_q[0].tup);
               if (out_ready) begin
                  void'(exp_q.pop_front());
`ifdef SIGMOID_SEGMENT_FETCH_STATS_EN
                  if (stat_exp < 16'hFFFF) stat_exp++;
`endif
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0].acc + 2 <= cyc) begin
            check("late_out", 32'd0, 32'd1);
         end
         if (in_valid && in_ready) begin
            exp_q.push_back('{tup: model(in_x), acc: cyc});
         end
      end
   end

   task automatic send(input logic [7:0] x);
      int budget;
      budget   = 50;
      in_x     = x;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (!in_ready) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("drain_empty", exp_q.size(), 32'd0);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      rst         = 1'b0;
      in_x        = '0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;

      // Model pinned to hand-computed values.
      check("model_00", model(8'h00), {8'd8, 8'd12, 8'd4, 8'd0});
      check("model_18", model(8'h18), {8'd12, 8'd14, 8'd2, 8'd8});
      check("model_f8", model(8'hF8), {8'd4, 8'd8, 8'd4, 8'd8});
      check("model_80", model(8'h80), {8'd0, 8'd0, 8'd0, 8'd0});
      check("model_7f", model(8'h7F), {8'd16, 8'd16, 8'd0, 8'd15});

      #12;
      check("reset_valid", {31'b0, out_valid}, 32'd0);
      check("reset_outs", outs(), 32'd0);
      check("reset_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // x = 0: exact two-cycle latency.
      send(8'h00);
      @(negedge clk);
      check("x00_not_yet", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      check("x00_valid", {31'b0, out_valid}, 32'd1);
      check("x00_outs", outs(), {8'd8, 8'd12, 8'd4, 8'd0});
      drain();

      // Back-to-back with no bubble.
      send(8'h18);
      send(8'hF8);
      @(negedge clk);
      check("b2b_first", outs(), {8'd12, 8'd14, 8'd2, 8'd8});
      check("b2b_first_v", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
      check("b2b_second", outs(), {8'd4, 8'd8, 8'd4, 8'd8});
      check("b2b_second_v", {31'b0, out_valid}, 32'd1);
      drain();

      // Boundaries.
      send(8'h80);
      send(8'h7F);
      @(negedge clk);
      check("bound_80", outs(), {8'd0, 8'd0, 8'd0, 8'd0});
      @(negedge clk);
      check("bound_7f", outs(), {8'd16, 8'd16, 8'd0, 8'd15});
      drain();

      // Backpressure: pipe fills, in_ready drops, held data released in order.
      out_ready = 1'b0;
      send(8'h21);
      send(8'h32);
      in_x     = 8'h43;
      in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("bp_in_ready", {31'b0, in_ready}, 32'd0);
         check("bp_hold", outs(), model(8'h21));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(8'h43);
      send(8'hD4);
      send(8'hE5);
      drain();

      // Asynchronous reset with two samples in flight.
      send(8'h11);
      send(8'h22);
      rst = 1'b0;
      #1;
      check("rst_async_valid", {31'b0, out_valid}, 32'd0);
      check("rst_async_outs", outs(), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      send(8'h40);
      @(negedge clk);
      check("post_rst_not_yet", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      check("post_rst_valid", {31'b0, out_valid}, 32'd1);
      check("post_rst_outs", outs(), {8'd16, 8'd16, 8'd0, 8'd0});
      drain();

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         in_valid  = ($urandom_range(0, 9) < 7);
         in_x      = 8'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
      end
      drain();

`ifdef SIGMOID_SEGMENT_FETCH_STATS_EN
      pulse_reset();
      for (int i = 0; i < 300; i++) send(8'($urandom));
      drain();
      check("count_300", {16'b0, out_count}, 32'd300);
      in_valid = 1'b1;
      for (int i = 0; i < 65300; i++) begin
         in_x = 8'($urandom);
         @(posedge clk);
         #1;
      end
      drain();
      check("count_sat", {16'b0, out_count}, 32'h0000FFFF);
      send(8'h55);
      drain();
      check("count_sat_hold", {16'b0, out_count}, 32'h0000FFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
